// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag bit positions and skid-buffer state encoding for the ALU execute stage.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOT   = 3'd0,
        OP_AND   = 3'd1,
        OP_OR    = 3'd2,
        OP_XOR   = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_NEG   = 3'd6,
        OP_PASSB = 3'd7
    } alu_op_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/alu_func_comb.sv
// ALU result and {Z,N,C,V} flag generator; NEG is built from the complement of a plus one.
// Latency: purely combinational.
// Backpressure: none, the enclosing stage decides when results are captured.
module alu_func_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    alu_op_e          op_e;
    logic [WIDTH-1:0] not_a;
    logic [WIDTH-1:0] neg_a;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             carry;
    logic             ovf;

    assign op_e  = alu_op_e'(op);
    assign not_a = ~a;
    assign neg_a = not_a + ONE;
    assign sum   = {1'b0, a} + {1'b0, b};
    // Top bit of a + ~b + 1 is the no-borrow indication (a >= b unsigned).
    assign diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op_e)
            OP_NOT: result = not_a;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NEG: begin
                result = neg_a;
                carry  = (a == '0);
                ovf    = (a == MIN_NEG);
            end
            default: result = b;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage feeding writeback through a main register plus one skid register.
// Latency: 1 cycle from accept to out_valid when empty; 1 result/cycle with out_ready high.
// Backpressure: in_ready (registered) drops only when the skid register holds data.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
);

    skid_state_e      state;
    logic             accept;
    logic [WIDTH-1:0] fn_result;
    logic [3:0]       fn_flags;
    logic [WIDTH-1:0] skid_result;
    logic [3:0]       skid_flags;

    alu_func_comb #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) u_func (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (fn_result),
        .flags  (fn_flags)
    );

    assign accept = in_valid && in_ready;

    // out_result/out_flags are the main register itself, so they cannot move while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_EMPTY;
            out_valid   <= 1'b0;
            in_ready    <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
            skid_result <= '0;
            skid_flags  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        out_result <= fn_result;
                        out_flags  <= fn_flags;
                        out_valid  <= 1'b1;
                        state      <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !out_ready) begin
                        skid_result <= fn_result;
                        skid_flags  <= fn_flags;
                        in_ready    <= 1'b0;
                        state       <= ST_FULL;
                    end else if (accept) begin
                        out_result <= fn_result;
                        out_flags  <= fn_flags;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        out_result <= skid_result;
                        out_flags  <= skid_flags;
                        in_ready   <= 1'b1;
                        state      <= ST_ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    state     <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: driver pushes model results on accept, monitor compares on every valid output.
module tb_alu_exec_stage;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic [W-1:0] r;
        logic [3:0]   f;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [3:0]   out_flags;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   stall_cnt = 0;
    bit   rand_rdy = 1'b0;

    alu_exec_stage #(.WIDTH(W), .OP_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: plain wide-integer arithmetic, flags from range checks.
    function automatic exp_t model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        logic [W-1:0] r;
        bit     c = 1'b0;
        bit     v = 1'b0;
        longint ua = a;
        longint ub = b;
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint sr;
        case (op)
            0: r = ~a;
            1: r = a & b;
            2: r = a | b;
            3: r = a ^ b;
            4: begin
                r  = a + b;
                c  = (ua + ub) > 64'hFFFF_FFFF;
                sr = sa + sb;
                v  = (sr > SMAX) || (sr < SMIN);
            end
            5: begin
                r  = a - b;
                c  = (ua >= ub);
                sr = sa - sb;
                v  = (sr > SMAX) || (sr < SMIN);
            end
            6: begin
                r = 32'd0 - a;
                c = (a == 32'd0);
                v = (a == 32'h8000_0000);
            end
            default: r = b;
        endcase
        e.r = r;
        e.f = {(r == 32'd0), r[W-1], c, v};
        return e;
    endfunction

    task automatic send(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit done = 1'b0;
        in_op    = op[2:0];
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back(model(op, a, b));
                done = 1'b1;
            end else begin
                stall_cnt++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sbq.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    task automatic dchk(input string nm, input logic [W-1:0] r, input logic [3:0] f);
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_res"}, 64'(out_result), 64'(r));
        chk({nm, "_flags"}, 64'(out_flags), 64'(f));
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %0h want none", out_result);
            end else begin
                chk("mon_result", 64'(out_result), 64'(sbq[0].r));
                chk("mon_flags", 64'(out_flags), 64'(sbq[0].f));
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_result", 64'(out_result), 64'd0);
        chk("rst_flags", 64'(out_flags), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Directed corner vectors, one-cycle latency with out_ready high.
        out_ready = 1'b1;
        send(6, 32'h0000_0005, 32'h0);
        dchk("neg5", 32'hFFFF_FFFB, 4'b0100);
        send(6, 32'h8000_0000, 32'h0);
        dchk("neg_min", 32'h8000_0000, 4'b0101);
        send(6, 32'h0, 32'h0);
        dchk("neg_zero", 32'h0, 4'b1010);
        send(4, 32'h7FFF_FFFF, 32'h1);
        dchk("add_ovf", 32'h8000_0000, 4'b0101);
        send(4, 32'hFFFF_FFFF, 32'h1);
        dchk("add_carry", 32'h0, 4'b1010);
        send(5, 32'h3, 32'h5);
        dchk("sub_borrow", 32'hFFFF_FFFE, 4'b0100);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("empty_after_directed", 64'(out_valid), 64'd0);

        // Backpressure: fill main and skid, hold, then release in order.
        out_ready = 1'b0;
        send(0, 32'h0F0F_0F0F, 32'h0);
        send(3, 32'h0000_00FF, 32'h0000_000F);
        in_valid = 1'b0;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            dchk("bp_hold", 32'hF0F0_F0F0, 4'b0100);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        dchk("bp_second", 32'h0000_00F0, 4'b0000);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Streaming: back-to-back random ops must never stall.
        stall_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            send(int'($urandom_range(0, 7)), ra, rb);
        end
        in_valid = 1'b0;
        chk("stream_no_stall", 64'(stall_cnt), 64'd0);
        drain();

        // Random backpressure mixed with random traffic.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            rb = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
            send(int'($urandom_range(0, 7)), ra, rb);
        end
        rand_rdy  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset while FULL discards everything held.
        out_ready = 1'b0;
        send(4, 32'h1234_5678, 32'h1111_1111);
        send(2, 32'hA000_0000, 32'h0000_000A);
        in_valid = 1'b0;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1;
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_in_ready", 64'(in_ready), 64'd0);
        chk("rst2_result", 64'(out_result), 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_after_in_ready", 64'(in_ready), 64'd1);
        chk("rst2_after_out_valid", 64'(out_valid), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("rst2_no_stale", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
